// File: rtl/md_unit.sv
// md_unit: multiply/divide sequencer owning the HI/LO pair.
// Fixed-latency Busy window; results commit on the final count edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [4:0] MC = 5'(MULT_CYCLES);
    localparam logic [4:0] DC = 5'(DIV_CYCLES);

    logic [4:0]  count;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_nz, bm_nz;
    logic [31:0] q_u, r_u, q_m, r_m, q_s, r_s;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        // Divide by magnitudes so 0x80000000 / -1 wraps cleanly.
        a_mag  = a_q[31] ? -a_q : a_q;
        b_mag  = b_q[31] ? -b_q : b_q;
        b_nz   = (b_q == 32'd0) ? 32'd1 : b_q;
        bm_nz  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_u    = a_q / b_nz;
        r_u    = a_q % b_nz;
        q_m    = a_mag / bm_nz;
        r_m    = a_mag % bm_nz;
        q_s    = (a_q[31] ^ b_q[31]) ? -q_m : q_m;
        r_s    = a_q[31] ? -r_m : r_m;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else if (count == 5'd0) begin
            if (Start) begin
                unique case (MDOp)
                    3'd1, 3'd2: begin
                        op_q  <= MDOp;
                        a_q   <= A;
                        b_q   <= B;
                        count <= MC;
                        Busy  <= 1'b1;
                    end
                    3'd3, 3'd4: begin
                        op_q  <= MDOp;
                        a_q   <= A;
                        b_q   <= B;
                        count <= DC;
                        Busy  <= 1'b1;
                    end
                    3'd5: HI <= A;
                    3'd6: LO <= A;
                    default: ;
                endcase
            end
        end else begin
            count <= count - 5'd1;
            if (count == 5'd1) begin
                Busy <= 1'b0;
                unique case (op_q)
                    3'd1: {HI, LO} <= prod_s;
                    3'd2: {HI, LO} <= prod_u;
                    3'd3: if (b_q != 32'd0) begin
                        LO <= q_s;
                        HI <= r_s;
                    end
                    3'd4: if (b_q != 32'd0) begin
                        LO <= q_u;
                        HI <= r_u;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
